// File: rtl/gs2rgb_stream.sv
// Grayscale-to-RGB stream expander with frame-position tags and a 2-entry skid buffer.
// Define GS2RGB_FALSECOLOR_EN to replace gray replication with a heat-map palette.
module gs2rgb_stream #(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_restart,
    input  logic [7:0]  gs,
    input  logic        gs_valid,
    output logic        gs_ready,
    output logic [23:0] rgb,
    output logic        rgb_valid,
    input  logic        rgb_ready,
    output logic        sof,
    output logic        eol,
    output logic        eof
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

    state_e      state_q, state_d;
    logic [11:0] col_q, col_d;
    logic [11:0] row_q, row_d;
    // Buffer entries pack {rgb, sof, eol, eof} so the tag moves with its pixel.
    logic [26:0] out_q, out_d;
    logic [26:0] skid_q, skid_d;
    logic        gs_ready_q, gs_ready_d;

    logic        in_xfer;
    logic        out_xfer;
    logic        at_eol;
    logic        at_last_row;
    logic [26:0] in_px;

    function automatic logic [23:0] to_rgb(input logic [7:0] g);
`ifdef GS2RGB_FALSECOLOR_EN
        logic [8:0] d;
        d = {g, 1'b0};
        if (!g[7]) begin
            to_rgb = {8'h00, d[7:0], 8'hFF - d[7:0]};
        end else begin
            to_rgb = {d[7:0], 8'hFF - d[7:0], 8'h00};
        end
`else
        to_rgb = {g, g, g};
`endif
    endfunction

    assign in_xfer     = gs_valid && gs_ready_q;
    assign out_xfer    = (state_q != EMPTY) && rgb_ready;
    assign at_eol      = (col_q == 12'(IMG_W - 1));
    assign at_last_row = (row_q == 12'(IMG_H - 1));
    assign in_px       = {to_rgb(gs), (col_q == '0) && (row_q == '0), at_eol, at_eol && at_last_row};

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (in_xfer) begin
            if (at_eol) begin
                col_d = '0;
                row_d = at_last_row ? '0 : row_q + 12'd1;
            end else begin
                col_d = col_q + 12'd1;
            end
        end
        if (frame_restart) begin
            col_d = '0;
            row_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    out_d   = in_px;
                    state_d = ONE;
                end
            end
            ONE: begin
                case ({in_xfer, out_xfer})
                    2'b10: begin
                        skid_d  = in_px;
                        state_d = FULL;
                    end
                    2'b11: out_d = in_px;
                    2'b01: state_d = EMPTY;
                    default: ;
                endcase
            end
            FULL: begin
                if (out_xfer) begin
                    out_d   = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        gs_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            col_q      <= '0;
            row_q      <= '0;
            out_q      <= '0;
            skid_q     <= '0;
            gs_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
            gs_ready_q <= gs_ready_d;
        end
    end

    assign gs_ready  = gs_ready_q;
    assign rgb_valid = (state_q != EMPTY);
    assign rgb       = out_q[26:3];
    assign sof       = out_q[2];
    assign eol       = out_q[1];
    assign eof       = out_q[0];

endmodule

// File: tb/tb_gs2rgb_stream.sv
// Scoreboard bench for gs2rgb_stream: two instances (4x2 and 8x2 frames) share one stimulus stream.
module tb_gs2rgb_stream;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_restart = 1'b0;
    logic [7:0] gs = '0;
    logic       gs_valid = 1'b0;
    logic       rgb_ready = 1'b0;

    logic        gs_ready_o  [2];
    logic        rgb_valid_o [2];
    logic [23:0] rgb_o       [2];
    logic        sof_o       [2];
    logic        eol_o       [2];
    logic        eof_o       [2];

    int n_checks = 0;
    int n_fail   = 0;

    logic [26:0] q0[$];
    logic [26:0] q1[$];
    int          idx     [2];
    logic [26:0] held    [2];
    bit          hold_v  [2];
    bit          rand_en = 1'b0;

    always #5 clk = ~clk;

    gs2rgb_stream #(.IMG_W(4), .IMG_H(2)) u_a (
        .clk(clk), .rst_n(rst_n), .frame_restart(frame_restart),
        .gs(gs), .gs_valid(gs_valid), .gs_ready(gs_ready_o[0]),
        .rgb(rgb_o[0]), .rgb_valid(rgb_valid_o[0]), .rgb_ready(rgb_ready),
        .sof(sof_o[0]), .eol(eol_o[0]), .eof(eof_o[0])
    );

    gs2rgb_stream #(.IMG_W(8), .IMG_H(2)) u_b (
        .clk(clk), .rst_n(rst_n), .frame_restart(frame_restart),
        .gs(gs), .gs_valid(gs_valid), .gs_ready(gs_ready_o[1]),
        .rgb(rgb_o[1]), .rgb_valid(rgb_valid_o[1]), .rgb_ready(rgb_ready),
        .sof(sof_o[1]), .eol(eol_o[1]), .eof(eof_o[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] ref_rgb(input int g);
`ifdef GS2RGB_FALSECOLOR_EN
        int r;
        if (g < 128) return {8'd0, 8'(2 * g), 8'(255 - 2 * g)};
        r = (2 * (g - 128)) % 256;
        return {8'(r), 8'(255 - r), 8'd0};
`else
        return {8'(g), 8'(g), 8'(g)};
`endif
    endfunction

    // Position comes from the count of pixels accepted since the last restart.
    function automatic logic [26:0] ref_px(input int inst, input int g, input int k);
        int w, h, col, row;
        w   = (inst == 0) ? 4 : 8;
        h   = 2;
        col = k % w;
        row = (k / w) % h;
        return {ref_rgb(g), (k % (w * h)) == 0, col == w - 1, (col == w - 1) && (row == h - 1)};
    endfunction

    always @(negedge clk) begin
        logic [26:0] act;
        logic [26:0] e;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            idx    = '{0, 0};
            hold_v = '{1'b0, 1'b0};
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (gs_valid && gs_ready_o[i]) begin
                    if (i == 0) q0.push_back(ref_px(0, int'(gs), idx[0]));
                    else        q1.push_back(ref_px(1, int'(gs), idx[1]));
                    idx[i]++;
                end
                if (frame_restart) idx[i] = 0;
                act = {rgb_o[i], sof_o[i], eol_o[i], eof_o[i]};
                if (rgb_valid_o[i]) begin
                    if (hold_v[i]) chk($sformatf("stable_%0d", i), 32'(act), 32'(held[i]));
                    if (rgb_ready) begin
                        hold_v[i] = 1'b0;
                        if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_out_%0d: got %h expected no pixel", i, act);
                        end else begin
                            e = (i == 0) ? q0.pop_front() : q1.pop_front();
                            chk($sformatf("out_px_%0d", i), 32'(act), 32'(e));
                        end
                    end else begin
                        held[i]   = act;
                        hold_v[i] = 1'b1;
                    end
                end else begin
                    hold_v[i] = 1'b0;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_en) rgb_ready = 1'($urandom % 2);
    end

    task automatic send(input logic [7:0] v);
        int n;
        gs       = v;
        gs_valid = 1'b1;
        n        = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gs_ready_o[0] && n < 1000);
        if (!gs_ready_o[0]) chk("send_timeout", 32'(gs_ready_o[0]), 32'd1);
        @(posedge clk);
        #1;
        gs_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        step();
        rgb_ready = 1'b1;
        n = 0;
        while ((q0.size() + q1.size()) != 0 && n < 200) begin
            step();
            n++;
        end
        chk("drain_left", 32'(q0.size() + q1.size()), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rgb",       32'(rgb_o[0]),       32'd0);
        chk("rst_rgb_valid", 32'(rgb_valid_o[0]), 32'd0);
        chk("rst_sof",       32'(sof_o[0]),       32'd0);
        chk("rst_eol",       32'(eol_o[0]),       32'd0);
        chk("rst_eof",       32'(eof_o[0]),       32'd0);
        chk("rst_gs_ready",  32'(gs_ready_o[0]),  32'd1);

        step();
        rgb_ready = 1'b1;
        step();
        send(8'h7A);
        @(negedge clk);
        chk("lat_valid", 32'(rgb_valid_o[0]), 32'd1);
        chk("lat_rgb",   32'(rgb_o[0]),       32'(ref_rgb(8'h7A)));
        step();
        @(negedge clk);
        chk("lat_drop", 32'(rgb_valid_o[0]), 32'd0);

        step();
        frame_restart = 1'b1;
        step();
        frame_restart = 1'b0;
        for (int p = 0; p < 9; p++) send(8'(p));
        drain();

        rgb_ready = 1'b0;
        send(8'h10);
        send(8'h11);
        gs       = 8'h12;
        gs_valid = 1'b1;
        @(negedge clk);
        chk("full_gs_ready", 32'(gs_ready_o[0]), 32'd0);
        chk("full_rgb_hold", 32'(rgb_o[0]),      32'(ref_rgb(8'h10)));
        step();
        rgb_ready = 1'b1;
        send(8'h12);
        drain();

        rgb_ready = 1'b0;
        send(8'h33);
        send(8'h44);
        rst_n = 1'b0;
        #1;
        chk("arst_rgb_valid", 32'(rgb_valid_o[0]), 32'd0);
        chk("arst_gs_ready",  32'(gs_ready_o[0]),  32'd1);
        chk("arst_rgb",       32'(rgb_o[0]),       32'd0);
        step();
        rst_n = 1'b1;
        rgb_ready = 1'b1;
        step();

        rand_en = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            if ($urandom % 4 == 0) step();
            frame_restart = ($urandom % 64 == 0);
            send(8'($urandom));
            frame_restart = 1'b0;
        end
        rand_en = 1'b0;
        drain();

        frame_restart = 1'b1;
        step();
        frame_restart = 1'b0;
        for (int p = 0; p < 6; p++) send(8'(8'h20 + p));
        frame_restart = 1'b1;
        step();
        frame_restart = 1'b0;
        send(8'hA5);
        @(negedge clk);
        chk("restart_valid", 32'(rgb_valid_o[1]), 32'd1);
        chk("restart_sof_b", 32'(sof_o[1]),       32'd1);
        chk("restart_sof_a", 32'(sof_o[0]),       32'd1);
        drain();

        send(8'd0);
        send(8'd64);
        send(8'd128);
        send(8'd255);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gs2rgb_stream.md
Name: gs2rgb_stream

Overview:
- Expands the 8-bit grayscale pixel stream back to 24-bit RGB for the display/debug output path; the inverse direction of the grayscale reduction stage.
- Accepts gs/gs_valid from the detection pipeline and drives a valid/ready RGB stream with frame-position markers.
- Contains a 2-entry skid buffer, so a stalled downstream never drops pixels.

Parameters:
IMG_W, 640, pixels per line; legal range 2..4095
IMG_H, 480, lines per frame; legal range 2..4095

Ports:
clk  in  1  system clock; all logic on its rising edge
rst_n  in  1  asynchronous active-low reset
frame_restart  in  1  synchronous; clears the column and row counters
gs  in  8  grayscale pixel
gs_valid  in  1  input pixel present
gs_ready  out  1  block can accept an input pixel
rgb  out  24  output pixel {R[23:16], G[15:8], B[7:0]}
rgb_valid  out  1  output pixel present
rgb_ready  in  1  downstream accepts the output pixel
sof  out  1  current output pixel is col 0, row 0
eol  out  1  current output pixel is col IMG_W-1
eof  out  1  current output pixel is col IMG_W-1, row IMG_H-1

Behaviour:
- Interface: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset values:
  - rgb=0, rgb_valid=0, sof=0, eol=0, eof=0.
  - gs_ready=1 once rst_n is released.
  - col=0, row=0; both skid entries empty.
- Transfers:
  - Input transfer when gs_valid && gs_ready.
  - Output transfer when rgb_valid && rgb_ready.
- Position tagging:
  - Each accepted pixel is tagged with the current {col,row}; the tag yields its sof/eol/eof.
  - The tag travels with the pixel through the buffer.
- Counter update, on each input transfer:
  - col increments.
  - When col==IMG_W-1: col wraps to 0 and row increments.
  - When row==IMG_H-1 and col==IMG_W-1: row wraps to 0.
- frame_restart:
  - Forces col=0, row=0 next cycle.
  - If it coincides with an input transfer, that pixel is still tagged with the pre-restart position; the next pixel gets 0,0.
  - Pixels already buffered are unaffected.
- Conversion (default): rgb = {gs, gs, gs}; combinational from the accepted gs; registered into the output stage.
- Latency: 1 cycle from input transfer to rgb_valid when the output stage is empty.
- Buffer states:
  - EMPTY: rgb_valid=0, gs_ready=1.
  - ONE: output register valid, skid empty, gs_ready=1.
  - FULL: output register and skid both valid, gs_ready=0.
- Transitions:
  - EMPTY + input transfer -> ONE.
  - ONE + input transfer, no output transfer -> FULL; the new pixel goes to skid.
  - ONE + input transfer + output transfer -> ONE; the new pixel loads the output register.
  - ONE + output transfer only -> EMPTY.
  - FULL + output transfer -> ONE; skid moves to the output register. No input is possible because gs_ready=0.
- gs_ready is registered (driven from state, not from rgb_ready), so there is no combinational ready path.
- rgb, sof, eol and eof stay stable while rgb_valid=1 and rgb_ready=0.
- Pixel order is strictly preserved; there is no drop or duplication under any rgb_ready pattern.
- gs_valid asserted while gs_ready=0: the pixel is not taken and the counters do not move.
- Reset asserted mid-frame: everything returns immediately to reset values and buffered pixels are discarded.

Optional Feature:
- Macro: GS2RGB_FALSECOLOR_EN.
- Defined: heat-map conversion replaces replication, with d = 2*gs computed 9 bits wide:
  - gs<128: R=0, G=d[7:0], B=255-d[7:0].
  - gs>=128: R=(2*(gs-128))[7:0], G=255-R, B=0.
  - Example values: gs=0 -> 0x0000FF; gs=64 -> 0x0080 7F; gs=128 -> 0x00FF00; gs=255 -> 0xFE0100.
- Latency and handshake are unchanged.
- Not defined: plain replication; none of the heat-map logic is synthesized.

Test Plan:
- Reset, then gs=0x7A with gs_valid for 1 cycle, rgb_ready=1 -> next cycle rgb=0x7A7A7A, rgb_valid=1; then rgb_valid=0.
- IMG_W=4, IMG_H=2, 8 consecutive pixels 0..7, rgb_ready=1 -> sof on pixel 0 only; eol on pixels 3 and 7; eof on pixel 7; pixel 8 carries sof again.
- Stream 0x10,0x11,0x12 with rgb_ready=0 from cycle 1 -> gs_ready drops after 2 accepted pixels and rgb holds 0x101010; raising rgb_ready yields 0x10, 0x11, then 0x12 in order.
- Random rgb_ready (50%) over 1000 pixels -> output sequence equals input sequence with no loss; rgb is stable whenever stalled.
- frame_restart pulsed after pixel 5 of a line, IMG_W=8 -> the next accepted pixel has sof=1.
- rst_n low while FULL -> rgb_valid=0, gs_ready=1, rgb=0 immediately; with GS2RGB_FALSECOLOR_EN, gs=0,128,255 -> 0x0000FF, 0x00FF00, 0xFE0100.
